wave_sweep_reader: RTL and testbench
====================================

// Module: wave_sweep_reader
// PURPOSE
//  Read side of the double-buffered sample RAM filled by the capture block.
//  Capture writes 2^ADDR_W offset-binary samples into half {~read_index}; this
//  block sweeps half {read_index}, one frame per frame_start. It emits
//  consecutive-sample segment pairs over a valid/ready stream to the renderer.
//  It drives wave_display_idle, which releases capture to swap buffers.
// PARAMETERS
//  ADDR_W   8   log2 samples per buffer half; RAM address is ADDR_W+1 bits
//  DATA_W   8   sample width (unsigned, offset-binary)
//  RAM_LAT  1   sync RAM read latency in cycles (>=1)
// PORTS
//  clk                in   1         system clock
//  reset_n            in   1         synchronous reset, active low
//  frame_start        in   1         start-of-frame pulse; acted on only in IDLE
//  read_index         in   1         buffer half to read, from capture block
//  read_address       out  ADDR_W+1  RAM read address {buf_sel, addr}
//  read_data          in   DATA_W    RAM read data, valid RAM_LAT cycles after address
//  seg_valid          out  1         segment available
//  seg_ready          in   1         renderer accepts segment
//  seg_x              out  ADDR_W    sample index of seg_y_curr (1..2^ADDR_W-1)
//  seg_y_prev         out  DATA_W    sample at seg_x-1
//  seg_y_curr         out  DATA_W    sample at seg_x
//  wave_display_idle  out  1         high exactly when state==IDLE
// BEHAVIOUR
//  Reset (reset_n low at a clk edge): state IDLE, addr 0, buf_sel 0, lat 0,
//   prev/curr 0. Outputs: read_address 0, seg_valid 0, seg_x 0, seg_y_* 0,
//   wave_display_idle 1. Mid-frame reset aborts the frame; no segment completes.
//  States:
//   IDLE: if frame_start, latch buf_sel<=read_index, addr<=0, lat<=0 -> FETCH.
//   FETCH: read_address={buf_sel,addr}, held for RAM_LAT+1 cycles (lat 0..RAM_LAT).
//    On the lat==RAM_LAT cycle, read_data is valid and registered at that edge.
//    If addr==0: prev<=read_data, addr<=1, lat<=0, stay FETCH (no segment).
//    Else: curr<=read_data -> PRESENT.
//   PRESENT: seg_valid=1. seg_x=addr, seg_y_prev=prev, seg_y_curr=curr.
//    These outputs are stable while seg_ready is low.
//    On seg_valid&&seg_ready: prev<=curr.
//     If addr==all-ones -> IDLE. Else addr<=addr+1, lat<=0 -> FETCH.
//  2^ADDR_W-1 segments per frame. addr never wraps; terminal is all-ones.
//  buf_sel is frozen for the whole frame; read_index changes mid-frame are ignored.
//  frame_start outside IDLE is ignored and is not queued.
//  frame_start held high restarts on the cycle after return to IDLE.
//  read_address holds its last value in IDLE.
//  seg_valid is registered (from state); no combinational ready->valid path.
//  Timing, ready=1, RAM_LAT=1, frame_start at cycle 0:
//   FETCH addr0 cycles 1-2. Segment k: FETCH 3k..3k+1, PRESENT 3k+2.
//   First seg_valid at cycle 5. Last PRESENT at 767. Idle high again at 768.
// TESTING
//  1 Reset: reset_n=0 during segment x=40 -> next cycle seg_valid=0, idle=1,
//    read_address=0. A later frame_start starts cleanly at addr 0.
//  2 Full frame: RAM[{1,a}]=a, read_index=1, ready=1, frame_start@0 ->
//    first seg at cycle 5 (x=1,prev=0,curr=1) ... last (x=255,254,255) @767;
//    all addresses 9'h1xx; idle=1 @768.
//  3 Backpressure: seg_ready=0 for 10 cycles while x=17 pending -> seg_valid
//    held 1, seg_x=17 and data constant, read_address constant; resumes x=18.
//  4 Buffer freeze: read_index 0->1 at cycle 100 of a frame started with 0 ->
//    every read_address MSB=0 for that frame. Next frame uses 1.
//  5 Busy/back-to-back: frame_start pulses at cycles 50 and 300 are ignored.
//    frame_start held high -> new FETCH at cycle 769, idle high only cycle 768.
//  6 RAM_LAT=2: frame_start@0 -> FETCH addr0 cycles 1-3; first seg_valid at
//    cycle 7 with curr=RAM[{sel,1}]. Segment period 4 cycles.

Source files
------------

// File: rtl/wave_sweep_reader_if.sv
// ---------------------------------------------------------------------------
// wave_sweep_reader_if
//   Bundles the sample-RAM read bus and the segment stream of the waveform
//   sweep reader into one interface.
//
//   Signals
//     read_address  RAM read address {buf_sel, addr}        (reader -> RAM)
//     read_data     RAM read data, RAM_LAT cycles later     (RAM -> reader)
//     seg_valid     segment available                       (reader -> renderer)
//     seg_ready     renderer accepts the segment            (renderer -> reader)
//     seg_x         sample index of seg_y_curr              (reader -> renderer)
//     seg_y_prev    sample at seg_x-1                       (reader -> renderer)
//     seg_y_curr    sample at seg_x                         (reader -> renderer)
//
//   Modports
//     master  the sweep reader itself
//     slave   the RAM plus renderer side
// ---------------------------------------------------------------------------
interface wave_sweep_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W:0]   read_address;
    logic [DATA_W-1:0] read_data;
    logic              seg_valid;
    logic              seg_ready;
    logic [ADDR_W-1:0] seg_x;
    logic [DATA_W-1:0] seg_y_prev;
    logic [DATA_W-1:0] seg_y_curr;

    modport master (
        output read_address,
        input  read_data,
        output seg_valid,
        input  seg_ready,
        output seg_x,
        output seg_y_prev,
        output seg_y_curr
    );

    modport slave (
        input  read_address,
        output read_data,
        input  seg_valid,
        output seg_ready,
        input  seg_x,
        input  seg_y_prev,
        input  seg_y_curr
    );
endinterface

// File: rtl/wave_sweep_reader.sv
// ---------------------------------------------------------------------------
// wave_sweep_reader
//   Read side of the double-buffered sample RAM. Once per frame it sweeps the
//   buffer half chosen by read_index_i, reading samples 0..2^ADDR_W-1. It
//   emits one segment (x, y[x-1], y[x]) per sample from x=1 upwards over a
//   valid/ready stream. While it is idle it raises wave_display_idle_o, which
//   lets the capture block swap buffer halves.
//
//   Ports
//     clk                  system clock
//     reset_n              synchronous reset, active low
//     frame_start_i        start-of-frame pulse, only honoured while idle
//     read_index_i         buffer half to sweep, latched at frame start
//     wave_display_idle_o  high exactly while the reader is idle
//     bus                  RAM read bus and segment stream (master side)
// ---------------------------------------------------------------------------
module wave_sweep_reader #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start_i,
    input  logic                  read_index_i,
    output logic                  wave_display_idle_o,
    wave_sweep_reader_if.master   bus
);

    localparam int LAT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RAM_LAT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } state_t;

    state_t            state_q,   state_d;
    logic              bufSel_q,  bufSel_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [LAT_W-1:0]  lat_q,     lat_d;
    logic [DATA_W-1:0] prev_q,    prev_d;
    logic [DATA_W-1:0] curr_q,    curr_d;

    // State register. Reset is synchronous, so a reset in the middle of a
    // frame simply drops the reader back to IDLE with every register cleared;
    // the pending segment is never handed over.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            bufSel_q <= 1'b0;
            addr_q   <= '0;
            lat_q    <= '0;
            prev_q   <= '0;
            curr_q   <= '0;
        end else begin
            state_q  <= state_d;
            bufSel_q <= bufSel_d;
            addr_q   <= addr_d;
            lat_q    <= lat_d;
            prev_q   <= prev_d;
            curr_q   <= curr_d;
        end
    end

    // Next-state logic. In FETCH the address is held for RAM_LAT+1 cycles and
    // the data is captured on the last of them, when lat reaches RAM_LAT.
    // Sample 0 only primes prev, so the first segment appears at x=1. The
    // buffer half is captured once at frame start and never touched again
    // until the next frame, so capture may flip read_index freely mid-sweep.
    // The sweep stops at the all-ones address instead of wrapping.
    always_comb begin
        state_d  = state_q;
        bufSel_d = bufSel_q;
        addr_d   = addr_q;
        lat_d    = lat_q;
        prev_d   = prev_q;
        curr_d   = curr_q;
        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    bufSel_d = read_index_i;
                    addr_d   = '0;
                    lat_d    = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (lat_q == LAT_LAST) begin
                    if (addr_q == '0) begin
                        prev_d = bus.read_data;
                        addr_d = ADDR_W'(1);
                        lat_d  = '0;
                    end else begin
                        curr_d  = bus.read_data;
                        state_d = PRESENT;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            PRESENT: begin
                if (bus.seg_ready) begin
                    prev_d = curr_q;
                    if (addr_q == ADDR_LAST) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        lat_d   = '0;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers only. seg_valid depends on the
    // state alone, so there is no combinational path from seg_ready back to
    // seg_valid, and the segment fields stay frozen while the renderer
    // stalls. read_address keeps its last value while idle.
    always_comb begin
        bus.read_address    = {bufSel_q, addr_q};
        bus.seg_valid       = (state_q == PRESENT);
        bus.seg_x           = addr_q;
        bus.seg_y_prev      = prev_q;
        bus.seg_y_curr      = curr_q;
        wave_display_idle_o = (state_q == IDLE);
    end

endmodule

// File: tb/tb_wave_sweep_reader.sv
// ---------------------------------------------------------------------------
// tb_wave_sweep_reader
//   Self-checking bench for wave_sweep_reader. One instance uses RAM_LAT=1
//   and a second uses RAM_LAT=2. Both share a behavioural sample RAM. The
//   expected segments come from the RAM contents: segment x of buffer half
//   sel is (x, ram[sel][x-1], ram[sel][x]). The expected cycle timing comes
//   from the frame timeline: (RAM_LAT+1) cycles per fetch, plus one present
//   cycle per segment.
// ---------------------------------------------------------------------------
module tb_wave_sweep_reader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int NSEG   = (1 << ADDR_W) - 1;

    logic clk = 1'b0;
    logic reset_n;
    logic frameStart;
    logic frameStart2;
    logic readIndex;
    logic idle;
    logic idle2;

    wave_sweep_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    wave_sweep_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

    wave_sweep_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(1)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .frame_start_i       (frameStart),
        .read_index_i        (readIndex),
        .wave_display_idle_o (idle),
        .bus                 (bus)
    );

    wave_sweep_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(2)) dut2 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .frame_start_i       (frameStart2),
        .read_index_i        (readIndex),
        .wave_display_idle_o (idle2),
        .bus                 (bus2)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Sample RAM shared by both readers, with a one-stage and a two-stage
    // read pipeline.
    logic [DATA_W-1:0] ram [0:511];
    logic [DATA_W-1:0] pipe2;

    always @(posedge clk) begin
        bus.read_data  <= ram[bus.read_address];
        pipe2          <= ram[bus2.read_address];
        bus2.read_data <= pipe2;
    end

    // Cycle counter used to measure frame-relative timing.
    int cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [DATA_W-1:0] sample(input logic sel, input int idx);
        logic [8:0] a;
        a = {sel, 8'(idx)};
        return ram[a];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses frame_start for the cycle where frame0 is taken. It returns at
    // the falling edge of frame cycle 1.
    task automatic applyStimulus(input logic sel, input logic hold, output int frame0);
        @(negedge clk);
        readIndex  = sel;
        frameStart = 1'b1;
        frame0     = cycleCount;
        @(negedge clk);
        frameStart = hold;
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n;
        n = 0;
        while (!idle && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(idle), 32'd1);
    endtask

    task automatic randomizeRam();
        for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
    endtask

    // Runs one frame and checks every segment in order against the RAM
    // model. readyPct sets the renderer acceptance rate. stallX forces 10
    // stalled cycles while x=stallX is offered. flipAt toggles read_index at
    // that frame cycle. pulseA/pulseB inject stray frame_start pulses.
    task automatic runFrame(input logic sel, input int readyPct, input int stallX,
                            input int flipAt, input int pulseA, input int pulseB);
        int frame0;
        int rel;
        int expX;
        int n;
        int stall;
        int firstRel;
        logic [8:0] expAddr;
        applyStimulus(sel, 1'b0, frame0);
        checkOutput("frame.addr0", 32'(bus.read_address), 32'({sel, 8'h00}));
        expX     = 1;
        n        = 0;
        stall    = 0;
        firstRel = -1;
        while (expX <= NSEG && n < 5000) begin
            rel = cycleCount - frame0;
            if (rel == flipAt) readIndex = ~sel;
            frameStart = (rel == pulseA) || (rel == pulseB);
            checkOutput("frame.msb", 32'(bus.read_address[8]), 32'(sel));
            checkOutput("frame.busy", 32'(idle), 32'd0);
            if (bus.seg_valid && expX == stallX && stall < 10) begin
                bus.seg_ready = 1'b0;
                stall++;
            end else begin
                bus.seg_ready = ($urandom_range(0, 99) < readyPct);
            end
            if (bus.seg_valid) begin
                if (firstRel < 0) firstRel = rel;
                expAddr = {sel, 8'(expX)};
                checkOutput("frame.x",    32'(bus.seg_x),        32'(expX));
                checkOutput("frame.prev", 32'(bus.seg_y_prev),   32'(sample(sel, expX - 1)));
                checkOutput("frame.curr", 32'(bus.seg_y_curr),   32'(sample(sel, expX)));
                checkOutput("frame.addr", 32'(bus.read_address), 32'(expAddr));
                if (bus.seg_ready) expX++;
            end
            @(negedge clk);
            n++;
        end
        frameStart    = 1'b0;
        bus.seg_ready = 1'b1;
        checkOutput("frame.done", 32'(expX), 32'(NSEG + 1));
        checkOutput("frame.idleEnd", 32'(idle), 32'd1);
        if (stallX > 0) checkOutput("frame.stallCycles", 32'(stall), 32'd10);
        if (readyPct == 100 && stallX == 0) checkOutput("frame.firstRel", 32'(firstRel), 32'd5);
    endtask

    initial begin
        int frame0;
        int rel;
        int x;
        int n;
        logic sel;
        logic expValid;

        reset_n       = 1'b0;
        frameStart    = 1'b0;
        frameStart2   = 1'b0;
        readIndex     = 1'b0;
        bus.seg_ready = 1'b0;
        bus2.seg_ready = 1'b1;
        randomizeRam();
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("reset.valid", 32'(bus.seg_valid),    32'd0);
        checkOutput("reset.idle",  32'(idle),             32'd1);
        checkOutput("reset.addr",  32'(bus.read_address), 32'd0);
        checkOutput("reset.x",     32'(bus.seg_x),        32'd0);
        checkOutput("reset.prev",  32'(bus.seg_y_prev),   32'd0);
        checkOutput("reset.curr",  32'(bus.seg_y_curr),   32'd0);
        checkOutput("reset.idle2", 32'(idle2),            32'd1);
        reset_n = 1'b1;

        // Full frame on half 1 with ram[{1,a}]=a, renderer always ready, and
        // frame_start held high so that a second frame follows immediately.
        $display("[TB] full frame, frame_start held");
        for (int a = 0; a < 256; a++) ram[256 + a] = 8'(a);
        bus.seg_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, frame0);
        rel = cycleCount - frame0;
        while (rel <= 770) begin
            expValid = (rel >= 5) && (rel <= 767) && ((rel - 2) % 3 == 0);
            checkOutput("full.valid", 32'(bus.seg_valid), 32'(expValid));
            checkOutput("full.idle",  32'(idle),          32'(rel == 768));
            if (rel <= 767) checkOutput("full.msb", 32'(bus.read_address[8]), 32'd1);
            if (expValid) begin
                x = (rel - 2) / 3;
                checkOutput("full.x",    32'(bus.seg_x),      32'(x));
                checkOutput("full.prev", 32'(bus.seg_y_prev), 32'(x - 1));
                checkOutput("full.curr", 32'(bus.seg_y_curr), 32'(x));
            end
            if (rel == 769) checkOutput("full.restartAddr", 32'(bus.read_address), 32'h100);
            @(negedge clk);
            rel = cycleCount - frame0;
        end
        frameStart = 1'b0;
        waitIdle(1000, "full.secondFrameEnds");

        // Reset while segment x=40 is being offered, then a clean restart.
        $display("[TB] mid-frame reset");
        randomizeRam();
        sel = 1'($urandom);
        applyStimulus(sel, 1'b0, frame0);
        n = 0;
        while (!(bus.seg_valid && bus.seg_x == 8'd40) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst.reach40", 32'(bus.seg_valid && bus.seg_x == 8'd40), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("rst.valid", 32'(bus.seg_valid),    32'd0);
        checkOutput("rst.idle",  32'(idle),             32'd1);
        checkOutput("rst.addr",  32'(bus.read_address), 32'd0);
        checkOutput("rst.x",     32'(bus.seg_x),        32'd0);
        reset_n = 1'b1;
        runFrame(~sel, 100, 0, -1, -1, -1);

        // Renderer stalls for 10 cycles while x=17 is pending.
        $display("[TB] backpressure");
        runFrame(1'b1, 100, 17, -1, -1, -1);

        // read_index flips mid-frame and stray frame_start pulses arrive.
        $display("[TB] buffer freeze and ignored frame_start");
        randomizeRam();
        runFrame(1'b0, 100, 0, 100, 50, 300);
        runFrame(1'b1, 100, 0, -1, -1, -1);

        // Random backpressure, random halves, random disturbances.
        $display("[TB] randomized frames");
        for (int f = 0; f < 3; f++) begin
            randomizeRam();
            runFrame(1'($urandom), int'($urandom_range(30, 90)), 0,
                     int'($urandom_range(1, 700)), int'($urandom_range(1, 700)), -1);
        end

        // Two-cycle RAM latency on the second instance.
        $display("[TB] RAM_LAT=2");
        randomizeRam();
        sel = 1'($urandom);
        @(negedge clk);
        readIndex   = sel;
        frameStart2 = 1'b1;
        frame0      = cycleCount;
        @(negedge clk);
        frameStart2 = 1'b0;
        rel = cycleCount - frame0;
        while (rel <= 1025) begin
            expValid = (rel >= 7) && (rel <= 1023) && ((rel - 3) % 4 == 0);
            checkOutput("lat2.valid", 32'(bus2.seg_valid), 32'(expValid));
            checkOutput("lat2.idle",  32'(idle2),          32'(rel >= 1024));
            if (rel <= 3) checkOutput("lat2.addr0", 32'(bus2.read_address), 32'({sel, 8'h00}));
            if (expValid) begin
                x = (rel - 3) / 4;
                checkOutput("lat2.x",    32'(bus2.seg_x),      32'(x));
                checkOutput("lat2.prev", 32'(bus2.seg_y_prev), 32'(sample(sel, x - 1)));
                checkOutput("lat2.curr", 32'(bus2.seg_y_curr), 32'(sample(sel, x)));
            end
            @(negedge clk);
            rel = cycleCount - frame0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
